// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled SPI frame receiver committing checked payloads into register banks
// Synchronizes the SPI lines into clk, assembles bank-ID/payload/checksum frames and commits valid ones.
module spi_frame_rx #(
  parameter int FRAME_BYTES = 51,
  parameter int NUM_BANKS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CHECKSUM_EN = 1,
  parameter int TIME_BYTES  = 8,
  parameter int HOLD_CYCLES = 128
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clk_en,
  input  logic                               sclk,
  input  logic                               cs_n,
  input  logic                               mosi,
  output logic [NUM_BANKS*FRAME_BYTES*8-1:0] bank_data,
  output logic [NUM_BANKS-1:0]               bank_wr,
  output logic                               time_update,
  output logic                               frame_err,
  output logic [1:0]                         err_code,
  output logic [15:0]                        frame_cnt
);

  localparam int PW = FRAME_BYTES * 8;
  localparam int E  = (1 + FRAME_BYTES + CHECKSUM_EN) * 8;
  localparam int CW = $clog2(E + 2);
  localparam logic [CW-1:0] E_C    = CW'(E);
  localparam logic [CW-1:0] E_SAT  = CW'(E + 1);
  localparam logic [CW-1:0] ID_END = CW'(8);
  localparam logic [CW-1:0] PL_END = CW'(8 + PW);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECV    = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_COMMIT  = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_d1_q, sclk_d1_d, cs_d1_q, cs_d1_d, mosi_d1_q, mosi_d1_d;
  logic sclk_rise_q, sclk_rise_d, cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
  logic [2:0]                        state_q, state_d;
  logic [CW-1:0]                     bit_cnt_q, bit_cnt_d;
  logic [7:0]                        id_q, id_d, csum_q, csum_d, sum_q, sum_d, byte_q, byte_d;
  logic [PW-1:0]                     shadow_q, shadow_d;
  logic [NUM_BANKS*PW-1:0]           bank_data_q, bank_data_d;
  logic [NUM_BANKS-1:0]              bank_wr_q, bank_wr_d;
  logic                              time_update_q, time_update_d, frame_err_q, frame_err_d;
  logic [1:0]                        err_code_q, err_code_d;
  logic [15:0]                       frame_cnt_q, frame_cnt_d, timer_q, timer_d;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_d1_d     = sclk_sync_q[SYNC_STAGES-1];
    cs_d1_d       = cs_sync_q[SYNC_STAGES-1];
    mosi_d1_d     = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise_d   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_d1_q;
    cs_rise_d     = cs_sync_q[SYNC_STAGES-1] & ~cs_d1_q;
    cs_fall_d     = ~cs_sync_q[SYNC_STAGES-1] & cs_d1_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    id_d          = id_q;
    csum_d        = csum_q;
    sum_d         = sum_q;
    byte_d        = byte_q;
    shadow_d      = shadow_q;
    bank_data_d   = bank_data_q;
    bank_wr_d     = '0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_cnt_d   = frame_cnt_q;
    time_update_d = time_update_q;
    timer_d       = timer_q;

    if (time_update_q) begin
      if (timer_q == 16'd0) time_update_d = 1'b0;
      else                  timer_d = timer_q - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // cs_n low without a fresh falling edge means we joined a frame midway
        if (!cs_d1_q) begin
          if (cs_fall_q) begin
            state_d   = ST_RECV;
            bit_cnt_d = '0;
            sum_d     = 8'd0;
          end else begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: if (cs_d1_q) state_d = ST_IDLE;
      ST_RECV: begin
        if (cs_rise_q) begin
          state_d = ST_CHECK;
        end else if (sclk_rise_q) begin
          byte_d = {byte_q[6:0], mosi_d1_q};
          if (bit_cnt_q < ID_END)      id_d     = {id_q[6:0], mosi_d1_q};
          else if (bit_cnt_q < PL_END) shadow_d = {shadow_q[PW-2:0], mosi_d1_q};
          else if (bit_cnt_q < E_C)    csum_d   = {csum_q[6:0], mosi_d1_q};
          if (bit_cnt_q[2:0] == 3'd7 && bit_cnt_q < PL_END) sum_d = sum_q + byte_d;
          if (bit_cnt_q != E_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (bit_cnt_q != E_C) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end else if (id_q >= 8'(NUM_BANKS)) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else if (CHECKSUM_EN != 0 && csum_q != sum_q) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d     = ST_IDLE;
        err_code_d  = 2'd0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (id_q == 8'(b)) begin
            bank_data_d[b*PW +: PW] = shadow_q;
            bank_wr_d[b]            = 1'b1;
          end
        end
        if (id_q == 8'd0 && shadow_q[PW-1 -: TIME_BYTES*8] != '0) begin
          time_update_d = 1'b1;
          timer_d       = 16'(HOLD_CYCLES);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // synchronizers clear to low so a cs_n already low after reset is seen as a partial frame
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_d1_q     <= 1'b0;
      cs_d1_q       <= 1'b0;
      mosi_d1_q     <= 1'b0;
      sclk_rise_q   <= 1'b0;
      cs_rise_q     <= 1'b0;
      cs_fall_q     <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      id_q          <= 8'd0;
      csum_q        <= 8'd0;
      sum_q         <= 8'd0;
      byte_q        <= 8'd0;
      shadow_q      <= '0;
      bank_data_q   <= '0;
      bank_wr_q     <= '0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      frame_cnt_q   <= 16'd0;
      time_update_q <= 1'b0;
      timer_q       <= 16'd0;
    end else if (clk_en) begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_d1_q     <= sclk_d1_d;
      cs_d1_q       <= cs_d1_d;
      mosi_d1_q     <= mosi_d1_d;
      sclk_rise_q   <= sclk_rise_d;
      cs_rise_q     <= cs_rise_d;
      cs_fall_q     <= cs_fall_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      id_q          <= id_d;
      csum_q        <= csum_d;
      sum_q         <= sum_d;
      byte_q        <= byte_d;
      shadow_q      <= shadow_d;
      bank_data_q   <= bank_data_d;
      bank_wr_q     <= bank_wr_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_cnt_q   <= frame_cnt_d;
      time_update_q <= time_update_d;
      timer_q       <= timer_d;
    end
  end

  assign bank_data   = bank_data_q;
  assign bank_wr     = bank_wr_q;
  assign time_update = time_update_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
